// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 block padder.
package md5_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        START = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int BLOCK_WORDS = 16;
    localparam int LEN_WORD    = 14;
    localparam int MAX_BYTES   = 55;

    // Keep the k message bytes of a short final word and place the 0x80
    // marker in the byte just above them; a full word passes through.
    function automatic logic [31:0] last_word(input logic [31:0] data,
                                              input logic [1:0]  nbytes);
        logic [31:0] w;
        case (nbytes)
            2'd1:    w = {16'h0000, 8'h80, data[7:0]};
            2'd2:    w = {8'h00, 8'h80, data[15:0]};
            2'd3:    w = {8'h80, data[23:0]};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/md5_lane_tracker.sv
// Tracks which md5unit lanes are hashing and offers the lowest free one.
module md5_lane_tracker #(
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] done_i,
    input  logic             claim_i,
    input  logic             claim_lane_i,
    output logic             any_free_o,
    output logic             free_lane_o
);
    import md5_pkg::*;

    logic [LANES-1:0] busy_q;
    logic [LANES-1:0] done_prev_q;
    logic [LANES-1:0] rise_s;
    logic [LANES-1:0] set_s;

    // Done rising edges and the lane being claimed by a start pulse.
    always_comb begin
        rise_s = done_i & ~done_prev_q;
        set_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            set_s[i] = claim_i && (int'(claim_lane_i) == i);
        end
    end

    // Lowest-numbered free lane; scanning downward leaves the lowest one last.
    always_comb begin
        any_free_o  = 1'b0;
        free_lane_o = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free_o  = 1'b1;
                free_lane_o = 1'(i);
            end else begin
                any_free_o  = any_free_o;
            end
        end
    end

    // Busy bits: a claim wins over a coincident done edge, so a done that is
    // already high when the lane starts never frees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            done_prev_q <= '0;
        end else begin
            done_prev_q <= done_i;
            busy_q      <= set_s | (busy_q & ~rise_s);
        end
    end

endmodule

// File: rtl/md5_padder.sv
// Pads single-block messages for MD5 and loads them into a free md5unit lane.
module md5_padder #(
    parameter int LANES     = 2,
    parameter int MAX_BYTES = 55
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [1:0]       in_bytes,
    output logic             in_ready,
    output logic             md5_write,
    output logic [4:0]       md5_writeaddr,
    output logic [31:0]      md5_writedata,
    output logic [LANES-1:0] md5_start,
    input  logic [LANES-1:0] md5_done,
    output logic             msg_lane,
    output logic             err
);
    import md5_pkg::*;

    state_e           state_q;
    logic [3:0]       widx_q;
    logic [5:0]       count_q;
    logic             lane_q;
    logic             chosen_q;
    logic             pad80_q;
    logic             write_q;
    logic [4:0]       waddr_q;
    logic [31:0]      wdata_q;
    logic [LANES-1:0] start_q;
    logic             msg_lane_q;
    logic             err_q;

    logic             any_free_s;
    logic             free_lane_s;
    logic             claim_s;
    logic             ready_s;
    logic             accept_s;
    logic             over_s;
    logic             lane_d;
    logic [2:0]       add_s;
    logic [6:0]       count_d;

    assign claim_s  = (state_q == START);
    assign accept_s = in_valid && ready_s;

    md5_lane_tracker #(.LANES(LANES)) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .done_i       (md5_done),
        .claim_i      (claim_s),
        .claim_lane_i (lane_q),
        .any_free_o   (any_free_s),
        .free_lane_o  (free_lane_s)
    );

    // Input handshake: open in FILL when a lane is held or available, always in DRAIN.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            FILL:    ready_s = chosen_q || any_free_s;
            DRAIN:   ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Byte count after this word, overflow test and the lane this message uses.
    always_comb begin
        add_s  = 3'd4;
        lane_d = lane_q;
        if (in_last && (in_bytes != 2'd0)) begin
            add_s = {1'b0, in_bytes};
        end else begin
            add_s = 3'd4;
        end
        count_d = {1'b0, count_q} + {4'd0, add_s};
        over_s  = (count_d > 7'(MAX_BYTES));
        if (chosen_q) begin
            lane_d = lane_q;
        end else begin
            lane_d = free_lane_s;
        end
    end

    // Main sequencer: fill from the stream, pad to 16 words, start the lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            widx_q     <= 4'd0;
            count_q    <= 6'd0;
            lane_q     <= 1'b0;
            chosen_q   <= 1'b0;
            pad80_q    <= 1'b0;
            write_q    <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            start_q    <= '0;
            msg_lane_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            write_q <= 1'b0;
            start_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept_s) begin
                        lane_q   <= lane_d;
                        chosen_q <= 1'b1;
                        if (over_s && in_last) begin
                            // A 56-byte message ends on the overflowing word itself.
                            err_q    <= 1'b1;
                            chosen_q <= 1'b0;
                            widx_q   <= 4'd0;
                            count_q  <= 6'd0;
                        end else if (over_s) begin
                            state_q <= DRAIN;
                        end else begin
                            write_q <= 1'b1;
                            waddr_q <= {lane_d, widx_q};
                            wdata_q <= in_last ? last_word(in_data, in_bytes) : in_data;
                            widx_q  <= widx_q + 4'd1;
                            count_q <= count_d[5:0];
                            if (in_last) begin
                                state_q <= PAD;
                                pad80_q <= (in_bytes == 2'd0);
                            end
                        end
                    end
                end
                PAD: begin
                    write_q <= 1'b1;
                    waddr_q <= {lane_q, widx_q};
                    pad80_q <= 1'b0;
                    widx_q  <= widx_q + 4'd1;
                    if (widx_q == 4'(LEN_WORD)) begin
                        wdata_q <= {23'd0, count_q, 3'b000};
                    end else if (pad80_q) begin
                        wdata_q <= 32'h0000_0080;
                    end else begin
                        wdata_q <= 32'd0;
                    end
                    if (widx_q == 4'(BLOCK_WORDS - 1)) begin
                        state_q <= START;
                    end
                end
                START: begin
                    start_q    <= LANES'(1) << lane_q;
                    msg_lane_q <= lane_q;
                    chosen_q   <= 1'b0;
                    count_q    <= 6'd0;
                    widx_q     <= 4'd0;
                    state_q    <= FILL;
                end
                DRAIN: begin
                    if (in_valid && in_last) begin
                        err_q    <= 1'b1;
                        chosen_q <= 1'b0;
                        widx_q   <= 4'd0;
                        count_q  <= 6'd0;
                        state_q  <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready      = ready_s;
    assign md5_write     = write_q;
    assign md5_writeaddr = waddr_q;
    assign md5_writedata = wdata_q;
    assign md5_start     = start_q;
    assign msg_lane      = msg_lane_q;
    assign err           = err_q;

endmodule

// File: tb/tb_md5_padder.sv
// Randomized self-checking bench for md5_padder against a byte-level padding model.
module tb_md5_padder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        in_ready;
    logic        md5_write;
    logic [4:0]  md5_writeaddr;
    logic [31:0] md5_writedata;
    logic [1:0]  md5_start;
    logic [1:0]  md5_done;
    logic        msg_lane;
    logic        err;

    md5_padder dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_bytes      (in_bytes),
        .in_ready      (in_ready),
        .md5_write     (md5_write),
        .md5_writeaddr (md5_writeaddr),
        .md5_writedata (md5_writedata),
        .md5_start     (md5_start),
        .md5_done      (md5_done),
        .msg_lane      (msg_lane),
        .err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  msg [64];
    logic [31:0] exp_blk [16];
    logic [4:0]  wq_addr [$];
    logic [31:0] wq_data [$];
    int          st_cnt, st_cyc, err_cnt, err_cyc, t_acc;
    logic [1:0]  st_val;
    logic        st_lane;
    logic [1:0]  busy_m;

    // Observe everything the DUT drives toward md5unit, away from the clock edge.
    always @(negedge clk) begin
        if (md5_write) begin
            wq_addr.push_back(md5_writeaddr);
            wq_data.push_back(md5_writedata);
        end
        if (md5_start != 2'b00) begin
            st_cnt  = st_cnt + 1;
            st_val  = md5_start;
            st_lane = msg_lane;
            st_cyc  = cyc;
        end
        if (err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        wq_addr.delete();
        wq_data.delete();
        st_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    endtask

    // Standard MD5 padding of an n-byte message, built as a 64-byte array.
    task automatic build_expected(input int n);
        logic [7:0]  b [64];
        logic [63:0] bits;
        bits = 64'(n) * 64'd8;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < n; i++) b[i] = msg[i];
        b[n] = 8'h80;
        for (int i = 0; i < 8; i++) b[56 + i] = bits[8*i +: 8];
        for (int i = 0; i < 16; i++) exp_blk[i] = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    endtask

    task automatic push_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int guard = 0;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) check_eq("ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        if (last) t_acc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input int n, input int gapmax);
        int nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            push_word({msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]}, i == nw - 1, 2'(n % 4));
            if (gapmax > 0 && i < nw - 1) begin
                repeat ($urandom_range(gapmax, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic expect_block(input int n, input int lane);
        int guard = 0;
        int w;
        build_expected(n);
        w = (n - 1) / 4;
        while (st_cnt == 0 && guard < 60) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check_eq("start_count", 32'(st_cnt), 32'd1);
        check_eq("start_onehot", 32'(st_val), 32'd1 << lane);
        check_eq("msg_lane", 32'(st_lane), 32'(lane));
        check_eq("start_latency", 32'(st_cyc), 32'(t_acc + 16 - w));
        check_eq("err_quiet", 32'(err_cnt), 32'd0);
        check_eq("write_count", 32'(wq_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wq_addr.size(); i++) begin
            check_eq($sformatf("waddr%0d", i), 32'(wq_addr[i]), 32'({lane[0], 4'(i)}));
            check_eq($sformatf("wdata%0d", i), wq_data[i], exp_blk[i]);
        end
        busy_m[lane] = 1'b1;
        clear_obs();
    endtask

    task automatic expect_drop();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("err_count", 32'(err_cnt), 32'd1);
        check_eq("err_cycle", 32'(err_cyc), 32'(t_acc));
        check_eq("no_start", 32'(st_cnt), 32'd0);
        clear_obs();
    endtask

    task automatic run_msg(input int n, input int gap);
        int lane = busy_m[0] ? 1 : 0;
        send_msg(n, gap);
        if (n > 55) expect_drop();
        else expect_block(n, lane);
    endtask

    task automatic pulse_done(input int lane);
        md5_done[lane] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        md5_done[lane] = 1'b0;
        @(posedge clk);
        #1;
        busy_m[lane] = 1'b0;
    endtask

    task automatic expect_blocked(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_eq(tag, 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Deadlock guard so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_last  = 1'b0;
        in_bytes = 2'd0;
        md5_done = 2'b00;
        busy_m   = 2'b00;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_write", 32'(md5_write), 32'd0);
        check_eq("rst_start", 32'(md5_start), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // 42-byte message, in_valid held high from the first cycle.
        fill_random();
        msg[40] = 8'h33;
        msg[41] = 8'h85;
        run_msg(42, 0);
        pulse_done(0);

        // "abcd": full last word, marker goes into the next word.
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h64;
        run_msg(4, 0);
        pulse_done(0);

        // Largest accepted message, then the smallest dropped one, then recovery.
        fill_random();
        run_msg(55, 0);
        pulse_done(0);
        fill_random();
        run_msg(56, 0);
        fill_random();
        run_msg(20, 0);
        pulse_done(0);

        // Two messages with done low fill both lanes; the third must wait.
        fill_random();
        run_msg(12, 0);
        fill_random();
        run_msg(8, 0);
        expect_blocked("ready_both_busy", 5);
        pulse_done(0);
        fill_random();
        run_msg(16, 0);

        // done[1] already high at lane 1 start does not free it.
        pulse_done(1);
        md5_done[1] = 1'b1;
        @(posedge clk);
        #1;
        fill_random();
        run_msg(24, 0);
        expect_blocked("ready_done_held", 4);
        md5_done[1] = 1'b0;
        @(posedge clk);
        #1;
        md5_done[1] = 1'b1;
        @(posedge clk);
        #1;
        busy_m[1] = 1'b0;
        fill_random();
        run_msg(36, 0);
        md5_done[1] = 1'b0;
        pulse_done(0);

        // Reset in the middle of padding; lane 1 is still busy beforehand.
        fill_random();
        send_msg(8, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_write", 32'(md5_write), 32'd0);
        check_eq("midrst_start", 32'(md5_start), 32'd0);
        check_eq("midrst_err", 32'(err), 32'd0);
        check_eq("midrst_lane", 32'(msg_lane), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        reset  = 1'b0;
        busy_m = 2'b00;
        clear_obs();
        fill_random();
        run_msg(30, 0);
        fill_random();
        run_msg(3, 0);

        // Randomized lengths, contents, gaps and lane releases.
        for (int m = 0; m < 40; m++) begin
            if (busy_m == 2'b11) pulse_done(int'($urandom_range(1, 0)));
            else if (busy_m != 2'b00 && $urandom_range(1, 0) == 1) pulse_done(busy_m[0] ? 0 : 1);
            fill_random();
            run_msg(int'($urandom_range(62, 1)), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
